// File: rtl/simon_input_checker.sv
// rtl/simon_input_checker.sv - Simon Says button capture and sequence checker
module simon_input_checker #(
  parameter int DEBOUNCE_CYCLES = 84000,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic        M_CLOCK,
  input  logic        M_RESET_N,
  input  logic [3:0]  IO_PB,
  input  logic [31:0] seq_data,
  input  logic [2:0]  seq_len,
  input  logic        arm,
  output logic        busy,
  output logic [2:0]  step_idx,
  output logic [3:0]  pressed,
  output logic        press_valid,
  output logic        match,
  output logic        mismatch,
  output logic        timeout,
  output logic [7:0]  led_echo
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    CHECK        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t          state;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      sync_hi;
  logic [3:0]      stable;
  logic [3:0]      stable_d;
  logic [DW-1:0]   db_cnt [4];
  logic [3:0]      rise;
  logic [3:0]      press_code;
  logic            press_evt;
  logic [31:0]     seq_q;
  logic [2:0]      len_q;
  logic [TW-1:0]   timer;
  logic [3:0]      led_hi;
  logic            finish;
  logic [3:0]      exp_nib;

  // Two-flop synchronizer; buttons idle high so the flops reset released
  always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
    if (!M_RESET_N) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= IO_PB;
      sync2 <= sync1;
    end
  end

  assign sync_hi = ~sync2;

  // Per-button debounce: level must differ from stable for DEBOUNCE_CYCLES cycles
  always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
    if (!M_RESET_N) begin
      stable <= 4'h0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_hi[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEB_LAST) begin
          stable[i] <= sync_hi[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed debounced state for rising-edge detection
  always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
    if (!M_RESET_N) stable_d <= 4'h0;
    else            stable_d <= stable;
  end

  assign rise      = stable & ~stable_d;
  assign press_evt = |rise;
  assign exp_nib   = seq_q[{step_idx, 2'b00} +: 4];

  // Encode the highest-priority new press into the one-hot nibble format
  always_comb begin
    press_code = 4'h0;
    if (rise[0])      press_code = 4'b1000;
    else if (rise[1]) press_code = 4'b0100;
    else if (rise[2]) press_code = 4'b0010;
    else if (rise[3]) press_code = 4'b0001;
  end

  // Capture/check FSM with registered result pulses
  always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
    if (!M_RESET_N) begin
      state       <= IDLE;
      seq_q       <= 32'h0;
      len_q       <= 3'd0;
      step_idx    <= 3'd0;
      timer       <= '0;
      pressed     <= 4'h0;
      led_hi      <= 4'h0;
      finish      <= 1'b0;
      press_valid <= 1'b0;
      match       <= 1'b0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      press_valid <= 1'b0;
      match       <= 1'b0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            seq_q    <= seq_data;
            len_q    <= seq_len;
            step_idx <= 3'd0;
            timer    <= '0;
            led_hi   <= 4'h0;
            finish   <= 1'b0;
            state    <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (press_evt) begin
            pressed     <= press_code;
            led_hi      <= press_code;
            press_valid <= 1'b1;
            state       <= CHECK;
          end else if (TMO_EN && (timer == TMO_LAST)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (pressed == exp_nib) begin
            if (step_idx == len_q) begin
              match  <= 1'b1;
              finish <= 1'b1;
            end else begin
              step_idx <= step_idx + 3'd1;
              finish   <= 1'b0;
            end
          end else begin
            mismatch <= 1'b1;
            finish   <= 1'b1;
          end
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (stable == 4'h0) begin
            if (finish) begin
              state <= IDLE;
            end else begin
              timer <= '0;
              state <= WAIT_PRESS;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign led_echo = {led_hi, 4'h0};

endmodule

// File: tb/tb_simon_input_checker.sv
// tb/tb_simon_input_checker.sv - directed bench for simon_input_checker
module tb_simon_input_checker;

  logic        M_CLOCK;
  logic        M_RESET_N;
  logic [3:0]  IO_PB;
  logic [31:0] seq_data;
  logic [2:0]  seq_len;
  logic        arm;
  logic        busy;
  logic [2:0]  step_idx;
  logic [3:0]  pressed;
  logic        press_valid;
  logic        match;
  logic        mismatch;
  logic        timeout;
  logic [7:0]  led_echo;

  int checks;
  int failures;
  int pv_cnt;
  int match_cnt;
  int mm_cnt;
  int to_cnt;

  simon_input_checker #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .M_CLOCK(M_CLOCK),
    .M_RESET_N(M_RESET_N),
    .IO_PB(IO_PB),
    .seq_data(seq_data),
    .seq_len(seq_len),
    .arm(arm),
    .busy(busy),
    .step_idx(step_idx),
    .pressed(pressed),
    .press_valid(press_valid),
    .match(match),
    .mismatch(mismatch),
    .timeout(timeout),
    .led_echo(led_echo)
  );

  initial M_CLOCK = 1'b0;
  always #5 M_CLOCK = ~M_CLOCK;

  // Count every result pulse, sampled mid-cycle
  always @(negedge M_CLOCK) begin
    if (press_valid === 1'b1) pv_cnt++;
    if (match === 1'b1)       match_cnt++;
    if (mismatch === 1'b1)    mm_cnt++;
    if (timeout === 1'b1)     to_cnt++;
  end

  task automatic tick();
    @(posedge M_CLOCK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_arm(input logic [31:0] d, input logic [2:0] l);
    seq_data = d;
    seq_len  = l;
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
  endtask

  // Cycles from now until press_valid is seen, -1 if never within the bound
  task automatic wait_pv(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (lat < 0 && n < 40) begin
      tick();
      n++;
      if (press_valid === 1'b1) lat = n;
    end
  endtask

  task automatic test_reset();
    M_RESET_N = 1'b0;
    IO_PB     = 4'b0000;
    ticks(3);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++;
    if (step_idx !== 3'd0) begin failures++; $display("FAIL reset_step got=%0h exp=0", step_idx); end
    checks++;
    if (pressed !== 4'h0) begin failures++; $display("FAIL reset_pressed got=%0h exp=0", pressed); end
    checks++;
    if ({press_valid, match, mismatch, timeout} !== 4'h0)
      begin failures++; $display("FAIL reset_pulses got=%0h exp=0", {press_valid, match, mismatch, timeout}); end
    checks++;
    if (led_echo !== 8'h00) begin failures++; $display("FAIL reset_led got=%0h exp=0", led_echo); end
    IO_PB = 4'hF;
    tick();
    M_RESET_N = 1'b1;
    ticks(20);
    checks++;
    if (pv_cnt !== 0) begin failures++; $display("FAIL reset_release_pv got=%0d exp=0", pv_cnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_sequence();
    logic [3:0] drv [3];
    logic [3:0] code [3];
    logic [2:0] stp [3];
    logic       mt [3];
    int lat;
    int m0;
    drv  = '{4'b1101, 4'b1110, 4'b1011};
    code = '{4'h4, 4'h8, 4'h2};
    stp  = '{3'd1, 3'd2, 3'd2};
    mt   = '{1'b0, 1'b0, 1'b1};
    m0   = match_cnt;
    do_arm(32'h0000_0284, 3'd2);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL seq_armed_busy got=%0h exp=1", busy); end
    checks++;
    if (step_idx !== 3'd0) begin failures++; $display("FAIL seq_armed_step got=%0h exp=0", step_idx); end
    for (int k = 0; k < 3; k++) begin
      IO_PB = drv[k];
      wait_pv(lat);
      checks++;
      if (lat !== 7) begin failures++; $display("FAIL seq_latency[%0d] got=%0d exp=7", k, lat); end
      checks++;
      if (pressed !== code[k]) begin failures++; $display("FAIL seq_pressed[%0d] got=%0h exp=%0h", k, pressed, code[k]); end
      checks++;
      if (led_echo !== {code[k], 4'h0}) begin failures++; $display("FAIL seq_led[%0d] got=%0h exp=%0h", k, led_echo, {code[k], 4'h0}); end
      tick();
      checks++;
      if (match !== mt[k]) begin failures++; $display("FAIL seq_match[%0d] got=%0h exp=%0h", k, match, mt[k]); end
      checks++;
      if (mismatch !== 1'b0) begin failures++; $display("FAIL seq_mismatch[%0d] got=%0h exp=0", k, mismatch); end
      checks++;
      if (step_idx !== stp[k]) begin failures++; $display("FAIL seq_step[%0d] got=%0h exp=%0h", k, step_idx, stp[k]); end
      IO_PB = 4'hF;
      ticks(10);
      checks++;
      if (busy !== (k < 2)) begin failures++; $display("FAIL seq_busy_after_release[%0d] got=%0h exp=%0h", k, busy, (k < 2)); end
    end
    checks++;
    if (match_cnt !== m0 + 1) begin failures++; $display("FAIL seq_match_count got=%0d exp=%0d", match_cnt, m0 + 1); end
  endtask

  task automatic test_bounce();
    int p0;
    int m0;
    p0 = pv_cnt;
    m0 = match_cnt;
    do_arm(32'h0000_0001, 3'd0);
    IO_PB = 4'b0111;
    ticks(3);
    IO_PB = 4'hF;
    ticks(10);
    checks++;
    if (pv_cnt !== p0) begin failures++; $display("FAIL bounce_short_pv got=%0d exp=%0d", pv_cnt, p0); end
    IO_PB = 4'b0111;
    ticks(6);
    IO_PB = 4'hF;
    ticks(14);
    checks++;
    if (pv_cnt !== p0 + 1) begin failures++; $display("FAIL bounce_long_pv got=%0d exp=%0d", pv_cnt, p0 + 1); end
    checks++;
    if (pressed !== 4'h1) begin failures++; $display("FAIL bounce_pressed got=%0h exp=1", pressed); end
    checks++;
    if (match_cnt !== m0 + 1) begin failures++; $display("FAIL bounce_match got=%0d exp=%0d", match_cnt, m0 + 1); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bounce_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_mismatch();
    int lat;
    int mm0;
    mm0 = mm_cnt;
    do_arm(32'h0000_0001, 3'd0);
    IO_PB = 4'b1110;
    wait_pv(lat);
    checks++;
    if (pressed !== 4'h8) begin failures++; $display("FAIL mm_pressed got=%0h exp=8", pressed); end
    tick();
    checks++;
    if (mismatch !== 1'b1) begin failures++; $display("FAIL mm_pulse got=%0h exp=1", mismatch); end
    checks++;
    if (match !== 1'b0) begin failures++; $display("FAIL mm_match got=%0h exp=0", match); end
    checks++;
    if (step_idx !== 3'd0) begin failures++; $display("FAIL mm_step got=%0h exp=0", step_idx); end
    ticks(20);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mm_busy_held got=%0h exp=1", busy); end
    IO_PB = 4'hF;
    ticks(10);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mm_busy_released got=%0h exp=0", busy); end
    checks++;
    if (mm_cnt !== mm0 + 1) begin failures++; $display("FAIL mm_count got=%0d exp=%0d", mm_cnt, mm0 + 1); end
  endtask

  task automatic test_timeout();
    int n;
    int lat;
    int t0;
    int p0;
    t0  = to_cnt;
    do_arm(32'h0000_0008, 3'd0);
    n   = 0;
    lat = -1;
    while (lat < 0 && n < 100) begin
      tick();
      n++;
      if (timeout === 1'b1) lat = n;
    end
    checks++;
    if (lat !== 50) begin failures++; $display("FAIL to_cycle got=%0d exp=50", lat); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL to_busy got=%0h exp=0", busy); end
    p0 = pv_cnt;
    IO_PB = 4'b1110;
    ticks(15);
    IO_PB = 4'hF;
    ticks(10);
    checks++;
    if (pv_cnt !== p0) begin failures++; $display("FAIL to_idle_press got=%0d exp=%0d", pv_cnt, p0); end
    checks++;
    if (to_cnt !== t0 + 1) begin failures++; $display("FAIL to_count got=%0d exp=%0d", to_cnt, t0 + 1); end
  endtask

  task automatic test_simultaneous();
    int lat;
    int p0;
    p0 = pv_cnt;
    do_arm(32'h0000_0008, 3'd0);
    IO_PB = 4'b1010;
    wait_pv(lat);
    checks++;
    if (lat !== 7) begin failures++; $display("FAIL sim_latency got=%0d exp=7", lat); end
    checks++;
    if (pressed !== 4'h8) begin failures++; $display("FAIL sim_pressed got=%0h exp=8", pressed); end
    tick();
    checks++;
    if (match !== 1'b1) begin failures++; $display("FAIL sim_match got=%0h exp=1", match); end
    IO_PB = 4'hF;
    ticks(10);
    checks++;
    if (pv_cnt !== p0 + 1) begin failures++; $display("FAIL sim_pv_count got=%0d exp=%0d", pv_cnt, p0 + 1); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL sim_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_hold_and_reset_mid();
    int p0;
    int m0;
    int mm0;
    int t0;
    p0 = pv_cnt;
    do_arm(32'h0000_0048, 3'd1);
    IO_PB = 4'b1110;
    ticks(100);
    checks++;
    if (pv_cnt !== p0 + 1) begin failures++; $display("FAIL hold_pv_count got=%0d exp=%0d", pv_cnt, p0 + 1); end
    checks++;
    if (step_idx !== 3'd1) begin failures++; $display("FAIL hold_step got=%0h exp=1", step_idx); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%0h exp=1", busy); end
    checks++;
    if (led_echo !== 8'h80) begin failures++; $display("FAIL hold_led got=%0h exp=80", led_echo); end
    m0  = match_cnt;
    mm0 = mm_cnt;
    t0  = to_cnt;
    #2;
    M_RESET_N = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0h exp=0", busy); end
    checks++;
    if (step_idx !== 3'd0) begin failures++; $display("FAIL rstmid_step got=%0h exp=0", step_idx); end
    checks++;
    if (pressed !== 4'h0) begin failures++; $display("FAIL rstmid_pressed got=%0h exp=0", pressed); end
    checks++;
    if (led_echo !== 8'h00) begin failures++; $display("FAIL rstmid_led got=%0h exp=0", led_echo); end
    ticks(5);
    IO_PB = 4'hF;
    ticks(5);
    M_RESET_N = 1'b1;
    ticks(10);
    checks++;
    if ({match_cnt, mm_cnt, to_cnt} !== {m0, mm0, t0})
      begin failures++; $display("FAIL rstmid_pulses got=%0d/%0d/%0d exp=%0d/%0d/%0d", match_cnt, mm_cnt, to_cnt, m0, mm0, t0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_after_busy got=%0h exp=0", busy); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pv_cnt    = 0;
    match_cnt = 0;
    mm_cnt    = 0;
    to_cnt    = 0;
    M_RESET_N = 1'b0;
    IO_PB     = 4'b0000;
    seq_data  = 32'h0;
    seq_len   = 3'd0;
    arm       = 1'b0;
    test_reset();
    test_sequence();
    test_bounce();
    test_mismatch();
    test_timeout();
    test_simultaneous();
    test_hold_and_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
